// File: rtl/cfg_membank_defs_pkg.sv
// Shared definitions for the memory-bank (bl/wl) configuration writer:
// FSM state encoding and the default geometry used by the tile generators.
package cfg_membank_defs;

    localparam int NUM_BL_DEFAULT   = 66;
    localparam int NUM_WL_DEFAULT   = 66;
    localparam int WL_PULSE_DEFAULT = 2;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SHIFT = 3'd1;
    localparam logic [2:0] ST_SETUP = 3'd2;
    localparam logic [2:0] ST_PULSE = 3'd3;
    localparam logic [2:0] ST_HOLD  = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT,
        SETUP = ST_SETUP,
        PULSE = ST_PULSE,
        HOLD  = ST_HOLD,
        DONE  = ST_DONE
    } state_t;

endpackage

// File: rtl/cfg_wl_onehot_decoder.sv
// Row index to one-hot wordline decode; purely combinational, the parent
// registers the result so wl comes straight from flops.
module cfg_wl_onehot_decoder #(
    parameter int NUM_WL = 66
) (
    input  logic [$clog2(NUM_WL)-1:0] row_idx,
    input  logic                      enable,
    output logic [0:NUM_WL-1]         wl
);

    localparam int RW = $clog2(NUM_WL);

    // Compare-per-row keeps out-of-range indices from ever selecting a line.
    always_comb begin
        for (int i = 0; i < NUM_WL; i++) begin
            wl[i] = enable && (row_idx == RW'(i));
        end
    end

endmodule

// File: rtl/cfg_membank_writer.sv
// Serial-to-frame bitline loader with one wordline pulse per row for the
// memory-bank configuration interface of one tile column.
module cfg_membank_writer
    import cfg_membank_defs::*;
#(
    parameter int NUM_BL   = NUM_BL_DEFAULT,
    parameter int NUM_WL   = NUM_WL_DEFAULT,
    parameter int WL_PULSE = WL_PULSE_DEFAULT
) (
    input  logic                      prog_clk,
    input  logic                      pReset_n,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      cfg_valid,
    input  logic                      cfg_data,
    output logic                      cfg_ready,
    output logic [0:NUM_BL-1]         bl,
    output logic [0:NUM_WL-1]         wl,
    output logic                      busy,
    output logic                      done,
    output logic [$clog2(NUM_WL)-1:0] row_idx
);

    localparam int BW = $clog2(NUM_BL);
    localparam int RW = $clog2(NUM_WL);
    localparam int PW = $clog2(WL_PULSE + 1);

    localparam logic [BW-1:0] BIT_LAST   = BW'(NUM_BL - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(NUM_WL - 1);
    localparam logic [PW-1:0] PULSE_LAST = PW'(WL_PULSE - 1);

    state_t            state, state_nx;
    logic [BW-1:0]     bit_cnt, bit_cnt_nx;
    logic [RW-1:0]     row_nx;
    logic [PW-1:0]     pulse_cnt, pulse_cnt_nx;
    logic [0:NUM_WL-1] wl_nx;
    logic              pulse_nx;
    logic              shift_fire;

    assign cfg_ready  = (state == SHIFT);
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign shift_fire = cfg_ready && cfg_valid && !abort;
    assign pulse_nx   = (state_nx == PULSE);

    // NOTE: every comb output gets a default before the case, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nx     = state;
        bit_cnt_nx   = bit_cnt;
        row_nx       = row_idx;
        pulse_cnt_nx = pulse_cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx   = SHIFT;
                    bit_cnt_nx = '0;
                    row_nx     = '0;
                end
            end
            SHIFT: begin
                if (cfg_valid) begin
                    if (bit_cnt == BIT_LAST) state_nx = SETUP;
                    else                     bit_cnt_nx = bit_cnt + 1'b1;
                end
            end
            SETUP: begin
                state_nx     = PULSE;
                pulse_cnt_nx = '0;
            end
            PULSE: begin
                if (pulse_cnt == PULSE_LAST) state_nx = HOLD;
                else                         pulse_cnt_nx = pulse_cnt + 1'b1;
            end
            HOLD: begin
                if (row_idx == ROW_LAST) begin
                    state_nx = DONE;
                end else begin
                    state_nx   = SHIFT;
                    row_nx     = row_idx + 1'b1;
                    bit_cnt_nx = '0;
                end
            end
            DONE: begin
                state_nx   = IDLE;
                row_nx     = '0;
                bit_cnt_nx = '0;
            end
            default: state_nx = IDLE;
        endcase
        // Abort overrides whatever the case decided, including a final HOLD->DONE.
        if (abort) begin
            state_nx   = IDLE;
            bit_cnt_nx = '0;
            row_nx     = '0;
        end
    end

    cfg_wl_onehot_decoder #(.NUM_WL(NUM_WL)) u_wl_dec (
        .row_idx (row_idx),
        .enable  (pulse_nx),
        .wl      (wl_nx)
    );

    // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            row_idx   <= '0;
            pulse_cnt <= '0;
            wl        <= '0;
        end else begin
            state     <= state_nx;
            bit_cnt   <= bit_cnt_nx;
            row_idx   <= row_nx;
            pulse_cnt <= pulse_cnt_nx;
            wl        <= wl_nx;
        end
    end

    // NOTE: bl is a plain register bank driving the array, not a RAM, so it takes the async reset like any other flop.
    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            bl <= '0;
        end else if (state_nx == IDLE) begin
            bl <= '0;
        end else if (shift_fire) begin
            bl[bit_cnt] <= cfg_data;
        end
    end

endmodule
